// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, credit-limited memory requests, response FIFO, redirect flush
//
// Ports:
//   clk, rst                          rising-edge clock, synchronous active-high reset
//   imem_req_valid/ready/addr         word fetch request to instruction memory
//   imem_rsp_valid/data               in-order responses, never back-pressured
//   instr_valid/ready, instr, instr_pc  head of instruction buffer to decode
//   redirect, redirect_pc             one-cycle taken branch/jump with new fetch target
//   misalign_err                      (FETCH_MISALIGN_EN only) sticky misaligned-redirect flag
//
// Build option: define FETCH_MISALIGN_EN to add misalign_err and stall fetch after a
// misaligned redirect until the next aligned one. Without it, target low bits are cleared.

module fetch_unit #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
    parameter int                         FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc
`ifdef FETCH_MISALIGN_EN
    ,
    output logic                     misalign_err
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_STEP  = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] rsp_pc;
    logic [CW-1:0]            inflight;
    logic [CW-1:0]            drop_cnt;
    logic [CW-1:0]            count;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [DATA_WIDTH-1:0]    data_mem [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic                     misalign_q;

    logic [CW+1:0]            credit_sum;
    logic                     req_fire;
    logic                     rsp_keep;
    logic                     rsp_drop;
    logic                     pop;
    logic [ADDRESS_WIDTH-1:0] target_pc;

    // Every outstanding request (live or doomed) and every buffered word holds one
    // slot, so the FIFO cannot overflow however responses and pops interleave.
    assign credit_sum = {2'b00, inflight} + {2'b00, drop_cnt} + {2'b00, count};

    assign imem_req_valid = !rst && !redirect && !misalign_q
                            && (credit_sum < (CW+2)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response in a redirect cycle belongs to the pre-redirect stream and is dropped.
    assign rsp_keep  = imem_rsp_valid && (drop_cnt == '0) && !redirect;
    assign rsp_drop  = imem_rsp_valid && (drop_cnt != '0);
    assign target_pc = redirect_pc & ALIGN_MASK;

    assign instr_valid = !rst && (count != '0);
    assign instr       = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;
    assign pop         = instr_valid && instr_ready && !redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC & ALIGN_MASK;
            rsp_pc   <= RESET_PC & ALIGN_MASK;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (redirect) begin
            fetch_pc <= target_pc;
            rsp_pc   <= target_pc;
            inflight <= '0;
            // The response arriving now retires one outstanding request, live or doomed.
            drop_cnt <= drop_cnt + inflight - CW'(imem_rsp_valid);
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + WORD_STEP;
            end
            inflight <= inflight + CW'(req_fire) - CW'(rsp_keep);
            drop_cnt <= drop_cnt - CW'(rsp_drop);
            if (rsp_keep) begin
                wr_ptr <= wr_ptr + PW'(1);
                rsp_pc <= rsp_pc + WORD_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(rsp_keep) - CW'(pop);
        end
    end

    // Storage is not reset; count gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (!rst && rsp_keep) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect) begin
            misalign_q <= |redirect_pc[1:0];
        end
    end
    assign misalign_err = misalign_q;
`else
    assign misalign_q = 1'b0;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with memory and instruction-stream model

module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_EN
    logic        misalign_err;
`endif

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_EN
        , .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int ep; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    req_t        mem_q[$];
    ent_t        mq[$];
    logic [31:0] acc_q[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    int          first_acc = -1;
    int          first_val = -1;
    logic [31:0] fpc = RPC;
    logic        mis = 1'b0;

    logic        rst_i = 1'b1, ready_i = 1'b1, irdy_i = 1'b1, redir_i = 1'b0;
    logic [31:0] redir_pc_i = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    task automatic clear_logs();
        acc_q.delete(); pop_pc.delete(); pop_data.delete();
        first_acc = -1; first_val = -1;
    endtask

    // One clock: drive inputs, compare outputs against the model, then advance the model.
    task automatic tick();
        logic rsp, exp_rv, exp_iv, fire;
        ent_t e;
        rsp = !rst_i && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rst = rst_i; imem_req_ready = ready_i; instr_ready = irdy_i;
        redirect = redir_i; redirect_pc = redir_pc_i;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(mem_q[0].addr) : 32'h0;
        #1;
        exp_rv = !rst_i && !redir_i && !mis && (mem_q.size() + mq.size() < DEPTH);
        exp_iv = !rst_i && (mq.size() > 0);
        chk("req_valid", {63'b0, imem_req_valid}, {63'b0, exp_rv});
        if (exp_rv) chk("req_addr", {32'b0, imem_req_addr}, {32'b0, fpc});
        chk("instr_valid", {63'b0, instr_valid}, {63'b0, exp_iv});
        if (exp_iv) begin
            chk("instr", {32'b0, instr}, {32'b0, mq[0].data});
            chk("instr_pc", {32'b0, instr_pc}, {32'b0, mq[0].pc});
        end
        if (rst_i) chk("rst_instr", {instr, instr_pc}, 64'h0);
`ifdef FETCH_MISALIGN_EN
        if (!rst_i) chk("misalign_err", {63'b0, misalign_err}, {63'b0, mis});
`endif
        if (imem_req_valid && ready_i) begin
            acc_q.push_back(imem_req_addr);
            if (first_acc < 0) first_acc = cyc;
        end
        if (instr_valid && first_val < 0) first_val = cyc;
        if (instr_valid && irdy_i && !redir_i && !rst_i) begin
            pop_pc.push_back(instr_pc); pop_data.push_back(instr);
        end
        @(posedge clk);
        if (rst_i) begin
            mem_q.delete(); mq.delete(); fpc = RPC; mis = 1'b0;
        end else begin
            fire = exp_rv && ready_i;
            if (exp_iv && irdy_i && !redir_i) void'(mq.pop_front());
            if (rsp) begin
                req_t r;
                r = mem_q.pop_front();
                if (!redir_i && r.ep == epoch) begin
                    e.pc = r.addr; e.data = instr_of(r.addr);
                    mq.push_back(e);
                end
            end
            if (fire) mem_q.push_back('{addr: fpc, due: cyc + lat, ep: epoch});
            if (redir_i) begin
                mq.delete(); epoch++;
                fpc = {redir_pc_i[31:2], 2'b00};
`ifdef FETCH_MISALIGN_EN
                mis = (redir_pc_i[1:0] != 2'b00);
`endif
            end else if (fire) begin
                fpc = fpc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_i = 1'b1; redir_i = 1'b0; run(2); rst_i = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redir_i = 1'b1; redir_pc_i = pc; tick(); redir_i = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // Streaming fetch from reset, 1-cycle memory.
        lat = 1; ready_i = 1; irdy_i = 1;
        do_reset(); clear_logs();
        run(8);
        chk("t1_npops", {63'b0, pop_pc.size() >= 3}, 64'h1);
        chk("t1_acc0", {32'b0, acc_q[0]}, 64'h0);
        chk("t1_acc2", {32'b0, acc_q[2]}, 64'h8);
        chk("t1_pc0", {32'b0, pop_pc[0]}, 64'h0);
        chk("t1_pc1", {32'b0, pop_pc[1]}, 64'h4);
        chk("t1_pc2", {32'b0, pop_pc[2]}, 64'h8);
        chk("t1_data1", {32'b0, pop_data[1]}, 64'hC0DE0004);
        chk("t1_latency", 64'(first_val - first_acc), 64'd2);

        // Decode stalled: exactly two buffered, then drain with no gaps.
        do_reset(); clear_logs(); irdy_i = 0;
        run(6);
        chk("t2_acc_n", 64'(acc_q.size()), 64'd2);
        chk("t2_full_req", {63'b0, imem_req_valid}, 64'h0);
        chk("t2_head_pc", {32'b0, instr_pc}, 64'h0);
        irdy_i = 1;
        run(6);
        chk("t2_pop0", {32'b0, pop_pc[0]}, 64'h0);
        chk("t2_pop1", {32'b0, pop_pc[1]}, 64'h4);
        for (int i = 0; i < acc_q.size(); i++) chk("t2_seq", {32'b0, acc_q[i]}, 64'(4 * i));

        // Redirect with two in flight, 3-cycle memory.
        do_reset(); clear_logs(); lat = 3;
        redirect_to(32'h10);
        run(2);
        chk("t3_acc_n", 64'(acc_q.size()), 64'd2);
        chk("t3_acc1", {32'b0, acc_q[1]}, 64'h14);
        clear_logs();
        redirect_to(32'h100);
        run(10);
        chk("t3_first", {32'b0, pop_pc[0]}, 64'h100);
        // Redirect landing on the same cycle as a response.
        redirect_to(32'h40);
        for (int i = 0; i < 10 && !(mem_q.size() > 0 && mem_q[0].due == cyc); i++) tick();
        chk("t3_rsp_coincide", {63'b0, mem_q.size() > 0 && mem_q[0].due == cyc}, 64'h1);
        clear_logs();
        redirect_to(32'h300);
        run(10);
        chk("t3b_first", {32'b0, pop_pc[0]}, 64'h300);

        // Memory back-pressure holds the address.
        do_reset(); lat = 1; ready_i = 0;
        redirect_to(32'h20);
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_addr", {32'b0, imem_req_addr}, 64'h20);
        end
        ready_i = 1; tick(); ready_i = 0; tick();
        chk("t4_acc_n", 64'(acc_q.size()), 64'd1);
        chk("t4_acc0", {32'b0, acc_q[0]}, 64'h20);
        chk("t4_next_addr", {32'b0, imem_req_addr}, 64'h24);
        ready_i = 1;

        // Reset with one buffered and one in flight.
        do_reset(); clear_logs(); lat = 2; irdy_i = 0;
        run(3);
        rst_i = 1; tick(); rst_i = 0;
        chk("t5_ivalid", {63'b0, instr_valid}, 64'h0);
        chk("t5_addr", {32'b0, imem_req_addr}, {32'b0, RPC});
        clear_logs(); irdy_i = 1;
        run(6);
        chk("t5_restart", {32'b0, acc_q[0]}, {32'b0, RPC});

        // Misaligned redirect.
        do_reset(); clear_logs(); lat = 1;
        redirect_to(32'h102);
`ifdef FETCH_MISALIGN_EN
        run(4);
        chk("t6_err", {63'b0, misalign_err}, 64'h1);
        chk("t6_no_req", 64'(acc_q.size()), 64'd0);
        redirect_to(32'h200);
        run(6);
        chk("t6_err_clr", {63'b0, misalign_err}, 64'h0);
        chk("t6_first", {32'b0, pop_pc[0]}, 64'h200);
`else
        chk("t6_addr", {32'b0, imem_req_addr}, 64'h100);
        run(6);
        chk("t6_first", {32'b0, pop_pc[0]}, 64'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
